// File: rtl/arb_pkg.sv
// Shared types for the 8:1 mux select arbiter.
// Optional ARB_TIMEOUT_EN enables forced release after MAX_HOLD grant cycles.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: first set bit of mreq at or above ptr, wrapping.
// Used by mux81_arbiter; the caller applies any block mask (ARB_TIMEOUT_EN).
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] mreq,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (mreq[ptr + SEL_W'(k)]) begin
                idx   = ptr + SEL_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux81_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 8:1 mux.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module mux81_arbiter
    import arb_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_HOLD   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               timeout
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    if (SETTLE_CYC < 1 || MAX_HOLD < 2) begin : g_param_chk
        $error("mux81_arbiter: SETTLE_CYC must be >= 1, MAX_HOLD >= 2");
    end

    state_t             state, state_d;
    logic [SEL_W-1:0]   sel_d, ptr, ptr_d, pick;
    logic [NUM_REQ-1:0] gnt_d, mreq;
    logic               busy_d, found, own_req;
    logic [CW-1:0]      cnt, cnt_d;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);

    logic [HW-1:0]      hold, hold_d;
    logic [NUM_REQ-1:0] block, block_d;
    logic               timeout_d;

    assign mreq = req & ~block;
`else
    assign mreq    = req;
    assign timeout = 1'b0;
`endif

    assign own_req = req[sel];

    rr_pick8 u_pick (
        .mreq  (mreq),
        .ptr   (ptr),
        .idx   (pick),
        .found (found)
    );

    always_comb begin
        state_d = state;
        sel_d   = sel;
        gnt_d   = gnt;
        busy_d  = busy;
        ptr_d   = ptr;
        cnt_d   = cnt;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold;
        timeout_d = 1'b0;
        block_d   = block & req;
`endif
        unique case (state)
            ST_IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!own_req) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt == CW'(SETTLE_CYC - 1)) begin
                    gnt_d   = onehot(sel);
                    state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_GRANT: begin
                if (!own_req) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel + 1'b1;
                    state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (hold == HW'(MAX_HOLD - 1)) begin
                    gnt_d        = '0;
                    busy_d       = 1'b0;
                    ptr_d        = sel + 1'b1;
                    state_d      = ST_IDLE;
                    timeout_d    = 1'b1;
                    block_d[sel] = 1'b1;
                end else begin
                    hold_d = hold + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sel   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            gnt   <= gnt_d;
            busy  <= busy_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold    <= '0;
            block   <= '0;
            timeout <= 1'b0;
        end else begin
            hold    <= hold_d;
            block   <= block_d;
            timeout <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux81_arbiter.sv
// Scoreboard bench for mux81_arbiter: directed scenarios plus random traffic.
module tb_mux81_arbiter;

    localparam int SC = 2;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int mptr = 0;
    logic [7:0] mblock = 8'h00;
    logic       allow_tmo = 1'b0;
    logic [7:0] gprev = 8'h00;

    mux81_arbiter #(.SETTLE_CYC(SC), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [7:0] bit8(input int i);
        logic [7:0] v;
        v = 8'h00;
        v[i[2:0]] = 1'b1;
        return v;
    endfunction

    // Reference: first eligible requester at or after mptr, wrapping.
    function automatic int model_pick(input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(mptr + k) % 8]) return (mptr + k) % 8;
        end
        return -1;
    endfunction

    // Monitor: every grant rising edge must match the next expected owner.
    always @(negedge clk) begin
        if (gnt != 8'h00 && gprev == 8'h00) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got gnt %0h expected none", gnt);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("sb_gnt", 32'(gnt), 32'(bit8(e)));
                chk("sb_sel", 32'(sel), 32'(e));
            end
        end
        if (gnt != 8'h00) begin
            chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
            chk("gnt_busy", 32'(busy), 32'd1);
        end
        if (!allow_tmo) chk("no_timeout", 32'(timeout), 32'd0);
        gprev = gnt;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 8'h00;
        @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        mptr = 0;
        mblock = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start(input logic [7:0] r, output int w);
        @(negedge clk);
        req = r;
        w = model_pick(r & ~mblock);
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        chk("st_sel", 32'(sel), 32'(w));
        chk("st_busy", 32'(busy), 32'd1);
        chk("st_gnt0", 32'(gnt), 32'd0);
        for (int i = 1; i < SC; i++) begin
            @(posedge clk);
            #1;
            chk("settle_gnt0", 32'(gnt), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("gnt_on", 32'(gnt), 32'(bit8(w)));
    endtask

    task automatic drop_grant(input int w, input int hold);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_gnt", 32'(gnt), 32'(bit8(w)));
        end
        @(negedge clk);
        req[w[2:0]] = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_gnt", 32'(gnt), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        mptr = (w + 1) % 8;
    endtask

    initial begin
        int w;
        repeat (2) @(posedge clk);
        do_reset();

        start(8'h04, w);
        drop_grant(w, 2);

        do_reset();
        for (int n = 0; n < 9; n++) begin
            start(8'hFF, w);
            chk("rot_order", 32'(w), 32'(n % 8));
            drop_grant(w, 3);
        end

        start(8'h40, w);
        drop_grant(w, 1);
        start(8'h81, w);
        chk("wrap_7", 32'(w), 32'd7);
        drop_grant(w, 2);
        start(8'h81, w);
        chk("wrap_0", 32'(w), 32'd0);
        drop_grant(w, 2);

        do_reset();
        @(negedge clk);
        req = 8'h10;
        @(posedge clk);
        #1;
        chk("abort_sel", 32'(sel), 32'd4);
        chk("abort_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        req = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_busy0", 32'(busy), 32'd0);
            chk("abort_gnt0", 32'(gnt), 32'd0);
        end
        start(8'h11, w);
        chk("abort_next", 32'(w), 32'd0);
        drop_grant(w, 1);

        start(8'h04, w);
        drop_grant(w, 1);
        start(8'h20, w);
        do_reset();
        start(8'h24, w);
        chk("rst_next", 32'(w), 32'd2);
        drop_grant(w, 1);

        for (int n = 0; n < 30; n++) begin
            start(8'($urandom_range(1, 255)), w);
            drop_grant(w, int'($urandom_range(1, MH - 1)));
        end

`ifdef ARB_TIMEOUT_EN
        do_reset();
        start(8'h03, w);
        for (int i = 1; i < MH; i++) begin
            @(posedge clk);
            #1;
            chk("tmo_hold", 32'(gnt), 32'h01);
        end
        allow_tmo = 1'b1;
        @(posedge clk);
        #1;
        chk("tmo_gnt0", 32'(gnt), 32'd0);
        chk("tmo_busy0", 32'(busy), 32'd0);
        chk("tmo_pulse", 32'(timeout), 32'd1);
        mptr = 1;
        mblock = 8'h01;
        exp_q.push_back(model_pick(req & ~mblock));
        @(posedge clk);
        #1;
        chk("tmo_once", 32'(timeout), 32'd0);
        chk("tmo_sel1", 32'(sel), 32'd1);
        allow_tmo = 1'b0;
        repeat (SC) @(posedge clk);
        #1;
        chk("tmo_gnt1", 32'(gnt), 32'h02);
        drop_grant(1, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("blocked_idle", 32'(busy), 32'd0);
        end
        @(negedge clk);
        req = 8'h00;
        mblock = 8'h00;
        start(8'h01, w);
        chk("unblocked", 32'(w), 32'd0);
        drop_grant(w, 1);
`endif

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
